// File: rtl/axi_axis_writer.sv
// axi_axis_writer
// AXI4-Lite slave: every register write (any address) is pushed into a
// first-word-fall-through FIFO that drains through an AXI4-Stream master.
// Every read (any address) returns the current FIFO occupancy, zero-extended.
//
// Build option AXI_AXIS_WRITER_DROP_EN:
//   undefined - a write into a full FIFO stalls until a slot frees.
//   defined   - a write into a full FIFO is discarded with SLVERR and a
//               sticky overflow flag is reported in rdata[AXI_DATA_WIDTH-1].
module axi_axis_writer #(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]              FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]              CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]              CNT_ZERO = CW'(0);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);

  // Write capture and response state
  logic                      aw_held_r;
  logic                      w_held_r;
  logic [AXI_DATA_WIDTH-1:0] wdata_r;
  logic                      bvalid_r;
  logic [1:0]                bresp_r;

  // Read channel state
  logic                      rvalid_r;
  logic [AXI_DATA_WIDTH-1:0] rdata_r;

  // FIFO storage; the output register holds the head word
  logic [AXI_DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_r;
  logic [CW-1:0]             mem_cnt_r;
  logic [CW-1:0]             count_r;
  logic                      tvalid_r;
  logic [AXI_DATA_WIDTH-1:0] tdata_r;

  logic                      aw_hs_s;
  logic                      w_hs_s;
  logic                      accept_s;
  logic                      full_s;
  logic                      push_s;
  logic                      drop_s;
  logic                      pop_s;
  logic                      load_s;
  logic                      ar_hs_s;
  logic [CW-1:0]             count_nxt_s;
  logic [CW-1:0]             mem_cnt_nxt_s;
  logic [AXI_DATA_WIDTH-1:0] rdata_nxt_s;
  logic                      unused_addr_s;

`ifdef AXI_AXIS_WRITER_DROP_EN
  logic                      overflow_r;
`endif

  // Addresses carry no meaning for this port
  assign unused_addr_s = ^{s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = ~aw_held_r;
  assign s_axi_wready  = ~w_held_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_arready = ~rvalid_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = 2'b00;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = tvalid_r;

  // Handshake and FIFO control decode
  always_comb begin
    aw_hs_s  = s_axi_awvalid & ~aw_held_r;
    w_hs_s   = s_axi_wvalid & ~w_held_r;
    accept_s = aw_held_r & w_held_r & ~bvalid_r;
    full_s   = (count_r == FULL_CNT);
    push_s   = accept_s & ~full_s;
`ifdef AXI_AXIS_WRITER_DROP_EN
    drop_s   = accept_s & full_s;
`else
    drop_s   = 1'b0;
`endif
    pop_s    = tvalid_r & m_axis_tready;
    // Refill the output register whenever it is empty or being emptied
    load_s   = (mem_cnt_r != CNT_ZERO) & (~tvalid_r | pop_s);
    ar_hs_s  = s_axi_arvalid & ~rvalid_r;
  end

  // Occupancy arithmetic for the total count and the memory-only count
  always_comb begin
    count_nxt_s   = count_r;
    mem_cnt_nxt_s = mem_cnt_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
    if (push_s && !load_s) begin
      mem_cnt_nxt_s = mem_cnt_r + CNT_ONE;
    end else if (load_s && !push_s) begin
      mem_cnt_nxt_s = mem_cnt_r - CNT_ONE;
    end else begin
      mem_cnt_nxt_s = mem_cnt_r;
    end
  end

  // Status word returned on a read: occupancy plus optional overflow flag
  always_comb begin
    rdata_nxt_s           = '0;
    rdata_nxt_s[CW-1:0]   = count_r;
`ifdef AXI_AXIS_WRITER_DROP_EN
    rdata_nxt_s[AXI_DATA_WIDTH-1] = overflow_r;
`endif
  end

  // Capture AW/W independently and raise the B response on push or drop
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      wdata_r   <= '0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
    end else begin
      if (push_s || drop_s) begin
        aw_held_r <= 1'b0;
        w_held_r  <= 1'b0;
        bvalid_r  <= 1'b1;
        bresp_r   <= push_s ? 2'b00 : 2'b10;
      end else begin
        if (aw_hs_s) begin
          aw_held_r <= 1'b1;
        end
        if (w_hs_s) begin
          w_held_r <= 1'b1;
          wdata_r  <= s_axi_wdata;
        end
        if (bvalid_r && s_axi_bready) begin
          bvalid_r <= 1'b0;
        end
      end
    end
  end

  // FIFO memory write port; contents need no reset, pointers define validity
  always_ff @(posedge aclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata_r;
    end
  end

  // Pointers, counters and the registered stream output stage
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      mem_cnt_r <= '0;
      count_r   <= '0;
      tvalid_r  <= 1'b0;
      tdata_r   <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      mem_cnt_r <= mem_cnt_nxt_s;
      count_r   <= count_nxt_s;
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        tvalid_r <= 1'b1;
        tdata_r  <= mem_r[rd_ptr_r];
      end else if (pop_s) begin
        tvalid_r <= 1'b0;
      end
    end
  end

  // Read channel: occupancy snapshot taken at the AR handshake
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rdata_nxt_s;
    end else if (rvalid_r && s_axi_rready) begin
      rvalid_r <= 1'b0;
    end
  end

`ifdef AXI_AXIS_WRITER_DROP_EN
  // Sticky overflow: a drop sets it, the read that reports it clears it
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (ar_hs_s) begin
      overflow_r <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_axi_axis_writer.sv
// Self-checking bench for axi_axis_writer: table-driven single writes plus
// directed sequences for ordering, full-FIFO behaviour, streaming and reset.
module tb_axi_axis_writer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [15:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  int n_checks = 0;
  int n_fail   = 0;

  logic        mon_en = 1'b0;
  logic [31:0] exp_q[$];
  int          mon_rx = 0;

  typedef struct {
    logic [31:0] wdata;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_tdata;
  } vec_t;

  vec_t vecs[5];

  axi_axis_writer #(
    .AXI_DATA_WIDTH (32),
    .AXI_ADDR_WIDTH (16),
    .FIFO_DEPTH_LOG2(4)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 32'(s_axi_awready), 32'd1);
    check({tag, "_wready"},  32'(s_axi_wready),  32'd1);
    check({tag, "_bvalid"},  32'(s_axi_bvalid),  32'd0);
    check({tag, "_bresp"},   32'(s_axi_bresp),   32'd0);
    check({tag, "_arready"}, 32'(s_axi_arready), 32'd1);
    check({tag, "_rvalid"},  32'(s_axi_rvalid),  32'd0);
    check({tag, "_rdata"},   s_axi_rdata,        32'd0);
    check({tag, "_rresp"},   32'(s_axi_rresp),   32'd0);
    check({tag, "_tvalid"},  32'(m_axis_tvalid), 32'd0);
    check({tag, "_tdata"},   m_axis_tdata,       32'd0);
  endtask

  // Drive AW and W with independent start delays; return after both handshakes
  task automatic axi_write(input logic [31:0] data, input int aw_dly, input int w_dly);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_f;
    bit w_f;
    int c = 0;
    s_axi_wdata  = data;
    s_axi_awaddr = 16'(c + 4);
    while (!(aw_done && w_done) && c < 100) begin
      s_axi_awvalid = !aw_done && (c >= aw_dly);
      s_axi_wvalid  = !w_done && (c >= w_dly);
      aw_f = s_axi_awvalid && s_axi_awready;
      w_f  = s_axi_wvalid && s_axi_wready;
      tick();
      if (aw_f) aw_done = 1'b1;
      if (w_f)  w_done  = 1'b1;
      c++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check("write_handshake", 32'(aw_done && w_done), 32'd1);
  endtask

  // Wait (bounded) for bvalid, check bresp, then complete the B handshake
  task automatic wait_b(input logic [1:0] exp_resp);
    int c = 0;
    s_axi_bready = 1'b1;
    while (!s_axi_bvalid && c < 40) begin
      tick();
      c++;
    end
    check("bvalid_seen", 32'(s_axi_bvalid), 32'd1);
    check("bresp", 32'(s_axi_bresp), 32'(exp_resp));
    tick();
  endtask

  task automatic axi_read(output logic [31:0] data);
    int c = 0;
    s_axi_araddr  = 16'h0010;
    s_axi_arvalid = 1'b1;
    while (!s_axi_arready && c < 20) begin
      tick();
      c++;
    end
    tick();
    s_axi_arvalid = 1'b0;
    check("rvalid_latency", 32'(s_axi_rvalid), 32'd1);
    check("rresp", 32'(s_axi_rresp), 32'd0);
    data = s_axi_rdata;
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask

  task automatic drain(input int first, input int n);
    m_axis_tready = 1'b1;
    for (int i = 0; i < n; i++) begin
      int c = 0;
      while (!m_axis_tvalid && c < 20) begin
        tick();
        c++;
      end
      check("drain_word", m_axis_tdata, 32'(first + i));
      tick();
    end
    m_axis_tready = 1'b0;
  endtask

  // Stream scoreboard for the back-to-back phase; samples away from the edge
  always @(negedge aclk) begin
    if (mon_en && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stream_extra: got %h, expected no word", m_axis_tdata);
      end else begin
        check("stream_order", m_axis_tdata, exp_q.pop_front());
        mon_rx++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;

    vecs[0] = '{32'h12345678, 0, 0, 2'b00, 32'h12345678};
    vecs[1] = '{32'hDEADBEEF, 2, 0, 2'b00, 32'hDEADBEEF};
    vecs[2] = '{32'h00000001, 0, 3, 2'b00, 32'h00000001};
    vecs[3] = '{32'hFFFFFFFF, 1, 1, 2'b00, 32'hFFFFFFFF};
    vecs[4] = '{32'h00000000, 0, 0, 2'b00, 32'h00000000};

    aresetn       = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b1;
    s_axi_araddr  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    tick();
    aresetn = 1'b1;
    check_reset_outputs("reset");

    // Single writes: B one cycle and tvalid two cycles after the last handshake
    for (int i = 0; i < 5; i++) begin
      axi_write(vecs[i].wdata, vecs[i].aw_dly, vecs[i].w_dly);
      check("vec_b_early", 32'(s_axi_bvalid), 32'd0);
      check("vec_t_early", 32'(m_axis_tvalid), 32'd0);
      tick();
      check("vec_bvalid", 32'(s_axi_bvalid), 32'd1);
      check("vec_bresp", 32'(s_axi_bresp), 32'(vecs[i].exp_bresp));
      check("vec_t_n1", 32'(m_axis_tvalid), 32'd0);
      tick();
      check("vec_b_done", 32'(s_axi_bvalid), 32'd0);
      check("vec_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("vec_tdata", m_axis_tdata, vecs[i].exp_tdata);
      tick();
      check("vec_popped", 32'(m_axis_tvalid), 32'd0);
      axi_read(r);
      check("vec_count_idle", r, 32'd0);
    end

    // W three cycles ahead of AW
    s_axi_wdata  = 32'hA5A5A5A5;
    s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wfirst_wready_low", 32'(s_axi_wready), 32'd0);
      if (i < 2) tick();
    end
    check("wfirst_awready", 32'(s_axi_awready), 32'd1);
    s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("wfirst_wready_pre_push", 32'(s_axi_wready), 32'd0);
    check("wfirst_b_pre_push", 32'(s_axi_bvalid), 32'd0);
    tick();
    check("wfirst_wready_after", 32'(s_axi_wready), 32'd1);
    check("wfirst_bvalid", 32'(s_axi_bvalid), 32'd1);
    tick();
    check("wfirst_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("wfirst_tdata", m_axis_tdata, 32'hA5A5A5A5);
    tick();
    check("wfirst_one_word_a", 32'(m_axis_tvalid), 32'd0);
    tick();
    check("wfirst_one_word_b", 32'(m_axis_tvalid), 32'd0);

    // Fill the FIFO with tready low
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      axi_write(32'(i), 0, 0);
      wait_b(2'b00);
    end
    axi_read(r);
    check("full_count", r, 32'd16);
`ifdef AXI_AXIS_WRITER_DROP_EN
    axi_write(32'd16, 0, 0);
    wait_b(2'b10);
    axi_read(r);
    check("drop_overflow_read", r, 32'h80000010);
    axi_read(r);
    check("drop_overflow_cleared", r, 32'h00000010);
    drain(0, 16);
`else
    axi_write(32'd16, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("stall_no_bvalid", 32'(s_axi_bvalid), 32'd0);
      check("stall_aw_held", 32'(s_axi_awready), 32'd0);
      tick();
    end
    check("stall_head_valid", 32'(m_axis_tvalid), 32'd1);
    check("stall_head_word", m_axis_tdata, 32'd0);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    wait_b(2'b00);
    drain(1, 16);
`endif
    check("drained_empty", 32'(m_axis_tvalid), 32'd0);
    axi_read(r);
    check("drained_count", r, 32'd0);

    // Back-to-back random writes with the stream always ready
    m_axis_tready = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] d;
      d = $urandom;
      exp_q.push_back(d);
      axi_write(d, 0, 0);
      wait_b(2'b00);
      if ((i % 100) == 99) begin
        axi_read(r);
        check("stream_count_bound", 32'(r <= 32'd16), 32'd1);
      end
    end
    repeat (6) tick();
    mon_en = 1'b0;
    check("stream_all_received", 32'(mon_rx), 32'd1000);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with 5 words buffered and an unacknowledged B response
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi_write(32'h100 + 32'(i), 0, 0);
      wait_b(2'b00);
    end
    s_axi_bready = 1'b0;
    axi_write(32'h104, 0, 0);
    tick();
    check("prerst_bvalid", 32'(s_axi_bvalid), 32'd1);
    check("prerst_tvalid", 32'(m_axis_tvalid), 32'd1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    check_reset_outputs("midrst");
    s_axi_bready = 1'b1;
    axi_read(r);
    check("midrst_count", r, 32'd0);
    tick();
    check("midrst_no_stream", 32'(m_axis_tvalid), 32'd0);
    check("midrst_no_b", 32'(s_axi_bvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
